// File: rtl/uart_tx_fifo_serializer.sv
// Transmit sink: byte FIFO fed by the frame builder, drained by an 8N1 UART serializer.
// uart_tx is registered from the current FSM state, so the line lags the state by one cycle.
module uart_tx_fifo_serializer #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_fifo_data,
    input  logic                          tx_fifo_wr_en,
    output logic                          tx_fifo_full,
    output logic                          tx_fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count,
    output logic                          tx_overflow,
    output logic                          uart_tx,
    output logic                          tx_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;
    logic          push;
    logic          pop;
    logic          bit_end;

    // Full/empty come from the registered count, so the writer may gate wr_en on them.
    assign tx_fifo_full  = (count_q == DEPTH_C);
    assign tx_fifo_empty = (count_q == '0);
    assign tx_fifo_count = count_q;
    assign tx_overflow   = ovf_q;
    assign uart_tx       = tx_q;
    assign tx_busy       = (state_q != S_IDLE);

    assign push    = tx_fifo_wr_en && !tx_fifo_full;
    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        ovf_d    = ovf_q | (tx_fifo_wr_en & tx_fifo_full);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!tx_fifo_empty)             state_d = S_START;
            S_START: if (bit_end)                    state_d = S_DATA;
            S_DATA:  if (bit_end && bit_q == 3'd7)   state_d = S_STOP;
            S_STOP:  if (bit_end)                    state_d = S_IDLE;
            default:                                 state_d = S_IDLE;
        endcase
    end

    // Output logic: pop strobe and the next line level.
    always_comb begin
        pop  = 1'b0;
        tx_d = 1'b1;
        unique case (state_q)
            S_IDLE:  pop  = !tx_fifo_empty;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Baud/bit counters and shift register; bit_q wraps back to 0 after bit 7.
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            baud_d  = '0;
            bit_d   = '0;
        end else if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
            if (state_q == S_DATA && bit_end) begin
                shift_d = {1'b0, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage has no reset; stale entries are never read because count gates pops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_fifo_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// Randomized and directed bench for uart_tx_fifo_serializer with a queue-based
// reference model, a scoreboard of expected frames and a line-decoding monitor.
module tb_uart_tx_fifo_serializer;

    localparam int C  = 4;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          wr  = 1'b0;
    logic          full, empty, ovf, line, busy;
    logic [CW-1:0] cnt;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo_serializer #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_fifo_data  (din),
        .tx_fifo_wr_en (wr),
        .tx_fifo_full  (full),
        .tx_fifo_empty (empty),
        .tx_fifo_count (cnt),
        .tx_overflow   (ovf),
        .uart_tx       (line),
        .tx_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, serializer as a "busy for 10 bit times" timer.
    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    logic [7:0] m_fifo[$];
    exp_t       exp_q[$];
    exp_t       m_e;
    int         m_busy = 0;
    bit         m_ovf  = 1'b0;
    bit         m_pop;
    bit         m_push;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_busy = 0;
            m_ovf  = 1'b0;
        end else begin
            m_pop  = (m_busy == 0) && (m_fifo.size() > 0);
            m_push = wr && (m_fifo.size() < D);
            if (wr && m_fifo.size() == D) m_ovf = 1'b1;
            if (m_pop) begin
                m_e.b = m_fifo.pop_front();
                m_e.t = cyc + 2;          // line falls one cycle after the popping edge
                exp_q.push_back(m_e);
                m_busy = 10 * C;
            end else if (m_busy > 0) begin
                m_busy--;
            end
            if (m_push) m_fifo.push_back(din);
        end
    end

    // Status flags against the model every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(cnt), m_fifo.size());
            chk("full", 32'(full), 32'(m_fifo.size() == D));
            chk("empty", 32'(empty), 32'(m_fifo.size() == 0));
            chk("overflow", 32'(ovf), 32'(m_ovf));
            chk("busy", 32'(busy), 32'(m_busy > 0));
        end
    end

    // Line monitor: decodes frames and checks them against the scoreboard.
    bit         mon_on = 1'b0;
    bit         mon_orphan;
    bit         mon_err;
    int         mon_p;
    int         slot;
    logic       expv;
    logic [7:0] mon_byte;
    exp_t       mon_e;
    int         frames = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_on = 1'b0;
        end else begin
            if (!mon_on && line === 1'b0) begin
                mon_on = 1'b1; mon_p = 0; mon_err = 1'b0; mon_byte = 8'h00;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    mon_orphan = 1'b1;
                    mon_e.b = 8'h00;
                    $display("FAIL start_unexpected: line fell at cycle %0d, required no frame", cyc);
                end else begin
                    mon_orphan = 1'b0;
                    mon_e = exp_q.pop_front();
                    if (cyc != mon_e.t) begin
                        bad++;
                        $display("FAIL start_time: start at cycle %0d, required %0d", cyc, mon_e.t);
                    end
                end
            end
            if (mon_on) begin
                slot = mon_p / C;
                expv = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : mon_e.b[slot-1];
                if (line !== expv) mon_err = 1'b1;
                if (slot >= 1 && slot <= 8 && (mon_p % C) == C / 2) mon_byte[slot-1] = line;
                if (mon_p == 10 * C - 1) begin
                    mon_on = 1'b0;
                    frames++;
                    $display("rx frame %0d: byte=%02h expected=%02h cycle=%0d", frames, mon_byte, mon_e.b, cyc);
                    if (!mon_orphan) begin
                        chk("rx_byte", 32'(mon_byte), 32'(mon_e.b));
                        chk("frame_shape", 32'(mon_err), 32'd0);
                    end
                end
                mon_p++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] b);
        wr  = 1'b1;
        din = b;
        tick();
        wr  = 1'b0;
    endtask

    task automatic wait_idle(input string what);
        int n = 0;
        while (!(m_fifo.size() == 0 && m_busy == 0 && !mon_on)) begin
            tick();
            n++;
            if (n > 5000) begin
                total++; bad++;
                $display("FAIL timeout_%s: still busy after %0d cycles, required idle", what, n);
                return;
            end
        end
        repeat (3) tick();
    endtask

    // Returns when the next edge will pop with exactly 'level' bytes stored.
    task automatic wait_pop_at(input int level, input string what);
        int n = 0;
        while (!(m_busy == 0 && m_fifo.size() == level)) begin
            tick();
            n++;
            if (n > 2000) begin
                total++; bad++;
                $display("FAIL timeout_%s: pop at level %0d never seen", what, level);
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset_uart_tx", 32'(line), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_count", 32'(cnt), 32'd0);
        chk("reset_overflow", 32'(ovf), 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Single byte.
        push_one(8'h5A);
        wait_idle("single");

        // Response frame on consecutive cycles.
        push_one(8'h5A); push_one(8'h00); push_one(8'h20); push_one(8'hC3);
        wait_idle("frame");

        // Fill and overflow.
        for (int i = 0; i < 10; i++) push_one(8'h30 + 8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(cnt), 32'd8);
        chk("fill_overflow", 32'(ovf), 32'd1);
        wait_idle("fill");

        // Push coinciding with a pop at count 3.
        for (int i = 0; i < 4; i++) push_one(8'h41 + 8'(i));
        wait_pop_at(3, "pop3");
        push_one(8'h45);
        chk("pushpop_count", 32'(cnt), 32'd3);
        wait_idle("pushpop3");

        // Push coinciding with a pop while full.
        do_reset();
        chk("rst_clears_overflow", 32'(ovf), 32'd0);
        for (int i = 0; i < 9; i++) push_one(8'h60 + 8'(i));
        wait_pop_at(8, "pop8");
        push_one(8'hEE);
        chk("fullpop_count", 32'(cnt), 32'd7);
        chk("fullpop_overflow", 32'(ovf), 32'd1);
        wait_idle("pushpop8");

        // Pointer wrap, two bytes at a time.
        for (int k = 0; k < 10; k++) begin
            push_one(8'(2 * k));
            push_one(8'(2 * k + 1));
            wait_idle("wrap");
        end

        // Asynchronous reset during DATA bit 3 of a zero byte, two more queued.
        push_one(8'h00); push_one(8'hA5); push_one(8'h3C);
        begin
            int n = 0;
            while (m_busy != 22 && n < 200) begin tick(); n++; end
            chk("reach_bit3", m_busy, 32'd22);
        end
        chk("pre_reset_line_low", 32'(line), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_uart_tx", 32'(line), 32'd1);
        chk("midrst_count", 32'(cnt), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_overflow", 32'(ovf), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (60) tick();
        chk("post_reset_line", 32'(line), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Random traffic: heavy phase (overflows), then a light phase.
        for (int i = 0; i < 300; i++) begin
            wr  = ($urandom_range(0, 3) == 0);
            din = 8'($urandom);
            tick();
        end
        wr = 1'b0;
        wait_idle("rand_heavy");
        for (int i = 0; i < 300; i++) begin
            wr  = ($urandom_range(0, 40) == 0);
            din = 8'($urandom);
            tick();
        end
        wr = 1'b0;
        wait_idle("rand_light");

        chk("scoreboard_leftover", exp_q.size(), 32'd0);
        chk("final_line", 32'(line), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_fifo_serializer.md
# uart_tx_fifo_serializer

- Transmit-side sink for response frames produced by the frame builder.
- Buffers response bytes in an internal synchronous FIFO through a push interface that matches the builder's `tx_fifo_*` ports.
- Serializes the buffered bytes onto the UART TX line as 8N1 frames at a fixed baud divider.
- Sits between the frame builder and the device pin. Status outputs report FIFO occupancy and line activity to the bridge controller.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1085: clock cycles per UART bit (125 MHz / 115200). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 64: FIFO entries. Must be a power of two, ≥ 4.

Ports (clock and reset first):
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `tx_fifo_data`  input  8  byte to enqueue.
- `tx_fifo_wr_en`  input  1  push request; accepted when `tx_fifo_full` is low.
- `tx_fifo_full`  output  1  FIFO holds `FIFO_DEPTH` bytes. Combinational from registered count only.
- `tx_fifo_empty`  output  1  FIFO holds 0 bytes.
- `tx_fifo_count`  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- `tx_overflow`  output  1  sticky; set by a push attempted while full; cleared only by `rst`.
- `uart_tx`  output  1  serial line; idles high.
- `tx_busy`  output  1  high whenever the serializer is not in IDLE.

## Operation
FIFO:
- A push occurs when `tx_fifo_wr_en && !tx_fifo_full`: data is written at the write pointer, and the pointer increments modulo `FIFO_DEPTH`.
- A pop occurs when the serializer is in IDLE and `!tx_fifo_empty`: the byte at the read pointer loads the shift register, and the read pointer increments modulo `FIFO_DEPTH`.
- Count update per cycle: +1 on push only, −1 on pop only, unchanged on push+pop or on neither.
- Push while full is dropped, the FIFO is unchanged, and `tx_overflow` is set on the next edge.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Full/empty are decoded from count, not from pointer comparison.

Serializer state machine (IDLE, START, DATA, STOP):
- **IDLE:** `uart_tx`=1. If `!tx_fifo_empty`, pop; go to START next cycle with bit counter 0 and baud counter 0.
- **START:** `uart_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:** `uart_tx`=shift[0]. Each bit is held `CLKS_PER_BIT` cycles, then the register shifts right and the bit counter increments. After bit 7 completes, go to STOP. Bytes are sent LSB first.
- **STOP:** `uart_tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- The baud counter runs 0..`CLKS_PER_BIT`−1; a bit ends when the counter equals `CLKS_PER_BIT`−1, and the counter then resets to 0.
- `uart_tx` is driven from a register, so there are no glitches.

## Timing
Reset values:
- `uart_tx`=1, `tx_busy`=0, `tx_fifo_full`=0, `tx_fifo_empty`=1, `tx_fifo_count`=0, `tx_overflow`=0.
- Pointers, counters and state are 0/IDLE.

Reset mid-operation:
- Reset takes effect immediately and asynchronously.
- The line returns high without completing the frame, and FIFO contents are discarded.

Latency:
- A push at edge N makes count=1 after N. IDLE pops at edge N+1. `uart_tx` falls after edge N+2.
- One frame lasts 10×`CLKS_PER_BIT` cycles, START entry to IDLE re-entry.

Back-to-back bytes:
- Exactly one IDLE cycle (line high) follows each stop bit before the next start bit.
- Byte period is 10×`CLKS_PER_BIT`+1 cycles.

Simultaneous events:
- Push and pop in the same cycle leave the count unchanged.
- When full, a push in the same cycle as a pop is still rejected, because full is evaluated on the pre-pop count.
- A pop never occurs when empty, so push to an empty FIFO never bypasses it.

Flags:
- `tx_fifo_full`/`tx_fifo_empty` change only on clock edges, so the upstream writer may gate `wr_en` combinationally on `tx_fifo_full` safely.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.

1. Single byte: push 0x5A into an idle block.
   - Required: `uart_tx` low for 4 cycles starting 2 cycles after the push edge.
   - Then bits 0,1,0,1,1,0,1,0 for 4 cycles each, then high for 4 cycles.
   - `tx_busy` high for exactly 40 cycles.
2. Response frame: push 0x5A, 0x00, 0x20, 0xC3 on consecutive cycles.
   - Required: the four bytes appear in order on the line.
   - Exactly 1 high idle cycle between each stop bit and the next start bit.
   - `tx_fifo_empty` returns to 1 after the 4th pop.
3. Fill and overflow: push 10 bytes on consecutive cycles.
   - Required: the first byte pops after 1 cycle, and `tx_fifo_full`=1 with count=8 after the 9th push.
   - The 10th push is dropped and `tx_overflow`=1.
   - All 9 accepted bytes are transmitted in order.
4. Simultaneous push and pop: with count=3 and the serializer in IDLE, push while the pop happens.
   - Required: count stays 3 and the pushed byte is transmitted 4th.
   - Repeat with count=8: the push is rejected, count becomes 7, and `tx_overflow` is set.
5. Pointer wrap: push and drain 20 bytes 0x00..0x13, two at a time.
   - Required: line output matches 0x00..0x13 in order across pointer wrap-around.
6. Reset mid-frame: assert `rst` during DATA bit 3 with 2 bytes queued.
   - Required: `uart_tx`=1 and count=0 immediately; `tx_overflow`=0.
   - After release, there is no transmission until a new push.
